// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter that shares one FIFO push port among NUM_REQ producers.
// Each owner pushes up to MAX_BURST beats, honouring fifo_full, before ownership rotates.
module fifo_push_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_push,
    output logic [DATA_WIDTH-1:0]         fifo_in_data,
    output logic                          busy,
    output logic [ID_W-1:0]               owner,
    output logic [15:0]                   beat_total
);

    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t                  state, state_n;
    logic [ID_W-1:0]         owner_n;
    logic [ID_W-1:0]         winner;
    logic [ID_W-1:0]         idx;
    logic                    winner_found;
    logic [CNT_W-1:0]        beat_cnt, beat_cnt_n;
    logic [15:0]             beat_total_n;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   slice [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Search starts one past the last owner, so owner doubles as the round-robin pointer.
    always_comb begin
        winner       = owner;
        winner_found = 1'b0;
        idx          = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((32'(owner) + k) % NUM_REQ);
            if (!winner_found && req[idx]) begin
                winner       = idx;
                winner_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        beat_cnt_n   = beat_cnt;
        beat_total_n = beat_total;
        gnt          = '0;
        fifo_in_data = '0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (winner_found) begin
                    state_n    = OWN;
                    owner_n    = winner;
                    beat_cnt_n = '0;
                end
            end
            OWN: begin
                fifo_in_data = slice[owner];
                accept       = req[owner] & ~fifo_full;
                gnt[owner]   = accept;
                if (accept) begin
                    beat_cnt_n   = beat_cnt + CNT_W'(1);
                    beat_total_n = beat_total + 16'd1;
                    if (beat_cnt == LAST_BEAT) begin
                        state_n = IDLE;
                    end
                end else if (!req[owner]) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign fifo_push = |gnt;
    assign busy      = (state == OWN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            owner      <= ID_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
            beat_total <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            beat_cnt   <= beat_cnt_n;
            beat_total <= beat_total_n;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: cycle table, beat scoreboard and
// hand-written corner sequences, plus a second instance for the beat_total wrap.
module tb_fifo_push_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            fifo_full;
    logic            fifo_push;
    logic [DW-1:0]   fifo_in_data;
    logic            busy;
    logic [1:0]      owner;
    logic [15:0]     beat_total;

    logic [1:0]      req2;
    logic [15:0]     req_data2;
    logic [1:0]      gnt2;
    logic            push2;
    logic [7:0]      in_data2;
    logic            busy2;
    logic            owner2;
    logic [15:0]     total2;

    always #5 clk = ~clk;

    fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_in_data(fifo_in_data),
        .busy(busy), .owner(owner), .beat_total(beat_total)
    );

    fifo_push_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(255)) dut_wrap (
        .clk(clk), .rstn(rstn), .req(req2), .req_data(req_data2), .gnt(gnt2),
        .fifo_full(1'b0), .fifo_push(push2), .fifo_in_data(in_data2),
        .busy(busy2), .owner(owner2), .beat_total(total2)
    );

    typedef struct {
        int unsigned   id;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic          exp_push;
        logic [DW-1:0] exp_data;
        logic          exp_busy;
        logic [1:0]    exp_owner;
        logic [15:0]   exp_total;
    } vec_t;

    beat_t         sb[$];
    int unsigned   rem  [N];
    int unsigned   sent [N];
    logic [DW-1:0] base [N];
    logic [N-1:0]  g;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_push_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req[i] = (rem[i] != 0);
            req_data[i*DW +: DW] = base[i] + sent[i];
        end
    endtask

    task automatic expect_beats(input int id, input int first, input int count);
        for (int j = 0; j < count; j++) begin
            sb.push_back('{id: id, data: base[id] + DW'(first + j)});
        end
    endtask

    // Negedge sampling: protocol invariants every cycle, scoreboard pop on each push.
    task automatic sample();
        int gi;
        @(negedge clk);
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("push_is_or_gnt", 32'(fifo_push), 32'(|gnt));
        check("no_push_when_full", 32'(fifo_push & fifo_full), 32'd0);
        gi = -1;
        for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
        if (fifo_push) begin
            last_push_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_push", 32'(gi), 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_id", 32'(gi), e.id);
                check("beat_data", fifo_in_data, e.data);
                if (gi >= 0) check("slice_match", fifo_in_data, req_data[gi*DW +: DW]);
            end
        end
        g = gnt;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                sent[i]++;
                rem[i]--;
            end
        end
        drive_inputs();
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic run(input int max_cycles);
        for (int k = 0; k < max_cycles && sb.size() != 0; k++) step();
        check("drain_timeout", sb.size(), 32'd0);
        step();
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < N; i++) begin
            rem[i]  = 0;
            sent[i] = 0;
            base[i] = '0;
        end
        fifo_full = 1'b0;
        drive_inputs();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd3);
        check("rst_total", 32'(beat_total), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_push", 32'(fifo_push), 32'd0);
        @(posedge clk);
        #1;
        cyc = 0;
        last_push_cyc = -1;
    endtask

    vec_t tv [11];

    initial begin
        int n;
        bit done;

        req = '0;
        req_data = '0;
        fifo_full = 1'b0;
        req2 = '0;
        req_data2 = '0;

        // Single requester: 4 beats, one bubble, 4 more beats.
        tv[0]  = '{1'b0, 32'h00, 1'b0, 2'd3, 16'd0};
        tv[1]  = '{1'b1, 32'hA0, 1'b1, 2'd0, 16'd0};
        tv[2]  = '{1'b1, 32'hA1, 1'b1, 2'd0, 16'd1};
        tv[3]  = '{1'b1, 32'hA2, 1'b1, 2'd0, 16'd2};
        tv[4]  = '{1'b1, 32'hA3, 1'b1, 2'd0, 16'd3};
        tv[5]  = '{1'b0, 32'h00, 1'b0, 2'd0, 16'd4};
        tv[6]  = '{1'b1, 32'hA4, 1'b1, 2'd0, 16'd4};
        tv[7]  = '{1'b1, 32'hA5, 1'b1, 2'd0, 16'd5};
        tv[8]  = '{1'b1, 32'hA6, 1'b1, 2'd0, 16'd6};
        tv[9]  = '{1'b1, 32'hA7, 1'b1, 2'd0, 16'd7};
        tv[10] = '{1'b0, 32'h00, 1'b0, 2'd0, 16'd8};

        do_reset();
        base[0] = 32'hA0;
        rem[0] = 8;
        expect_beats(0, 0, 8);
        drive_inputs();
        for (int i = 0; i < 11; i++) begin
            sample();
            check($sformatf("s1_push[%0d]", i), 32'(fifo_push), 32'(tv[i].exp_push));
            check($sformatf("s1_data[%0d]", i), fifo_in_data, tv[i].exp_data);
            check($sformatf("s1_busy[%0d]", i), 32'(busy), 32'(tv[i].exp_busy));
            check($sformatf("s1_owner[%0d]", i), 32'(owner), 32'(tv[i].exp_owner));
            check($sformatf("s1_total[%0d]", i), 32'(beat_total), 32'(tv[i].exp_total));
            advance();
        end

        // All four requesting: owners 0,1,2,3,0 with one idle cycle between bursts.
        do_reset();
        for (int i = 0; i < N; i++) begin
            base[i] = 32'h1000 * (i + 1);
            rem[i] = (i == 0) ? 8 : 4;
        end
        expect_beats(0, 0, 4);
        expect_beats(1, 0, 4);
        expect_beats(2, 0, 4);
        expect_beats(3, 0, 4);
        expect_beats(0, 4, 4);
        drive_inputs();
        run(60);
        check("s2_last_push_cyc", 32'(last_push_cyc), 32'd24);
        check("s2_total", 32'(beat_total), 32'd20);

        // Back-pressure: owner 1 stalls 5 cycles after 2 beats, then finishes, then rotation to 2.
        do_reset();
        base[1] = 32'h2100;
        base[2] = 32'h2200;
        rem[1] = 4;
        rem[2] = 1;
        expect_beats(1, 0, 4);
        expect_beats(2, 0, 1);
        drive_inputs();
        repeat (3) step();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("s3_stall_push", 32'(fifo_push), 32'd0);
            check("s3_stall_busy", 32'(busy), 32'd1);
            check("s3_stall_owner", 32'(owner), 32'd1);
            advance();
        end
        fifo_full = 1'b0;
        run(30);
        check("s3_last_push_cyc", 32'(last_push_cyc), 32'd11);
        check("s3_total", 32'(beat_total), 32'd5);

        // Early drop: requester 2 leaves after one beat, requester 3 takes over.
        do_reset();
        base[2] = 32'h3200;
        base[3] = 32'h3300;
        rem[2] = 1;
        rem[3] = 4;
        expect_beats(2, 0, 1);
        expect_beats(3, 0, 4);
        drive_inputs();
        repeat (2) step();
        sample();
        check("s4_drop_push", 32'(fifo_push), 32'd0);
        check("s4_drop_busy", 32'(busy), 32'd1);
        advance();
        sample();
        check("s4_idle_busy", 32'(busy), 32'd0);
        check("s4_idle_owner", 32'(owner), 32'd2);
        advance();
        sample();
        check("s4_new_owner", 32'(owner), 32'd3);
        check("s4_new_busy", 32'(busy), 32'd1);
        advance();
        run(30);
        check("s4_last_push_cyc", 32'(last_push_cyc), 32'd7);

        // Async reset during owner 3's second beat.
        do_reset();
        base[3] = 32'h4300;
        rem[3] = 4;
        expect_beats(3, 0, 1);
        drive_inputs();
        repeat (2) step();
        #2;
        check("s5_pre_push", 32'(fifo_push), 32'd1);
        check("s5_pre_gnt", 32'(gnt), 32'h8);
        rstn = 1'b0;
        #1;
        check("s5_async_push", 32'(fifo_push), 32'd0);
        check("s5_async_gnt", 32'(gnt), 32'd0);
        check("s5_async_data", fifo_in_data, 32'd0);
        check("s5_async_busy", 32'(busy), 32'd0);
        check("s5_async_owner", 32'(owner), 32'd3);
        check("s5_async_total", 32'(beat_total), 32'd0);
        check("s5_sb_empty", sb.size(), 32'd0);
        clear_model();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s5_push_in_reset", 32'(fifo_push), 32'd0);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            base[i] = 32'h5000 + 32'h100 * i;
            rem[i] = 1;
        end
        expect_beats(0, 0, 1);
        expect_beats(1, 0, 1);
        expect_beats(2, 0, 1);
        expect_beats(3, 0, 1);
        drive_inputs();
        run(40);

        // beat_total wrap on a long-burst instance.
        check("s6_total_start", 32'(total2), 32'd0);
        req_data2 = 16'h0055;
        req2 = 2'b01;
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 70000 && !done; k++) begin
            @(negedge clk);
            if (n == 65535) check("s6_total_ffff", 32'(total2), 32'hFFFF);
            if (n == 65536) check("s6_total_0000", 32'(total2), 32'h0000);
            if (n == 65537) begin
                check("s6_total_0001", 32'(total2), 32'h0001);
                done = 1'b1;
            end
            if (push2) begin
                if (n == 0) check("s6_data", 32'(in_data2), 32'h55);
                n++;
            end
        end
        check("s6_timeout", 32'(done), 32'd1);
        req2 = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
